// File: rtl/hc_copy_core_if.sv
// Core-side buffer port between hc_copy_core (master) and hc_requestor (slave).
// Request channels transfer on valid && ready; once valid rises, addr/data hold until that transfer; responses have no ready.
interface hc_copy_core_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32
);
  logic                  rd_req_valid;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_req_ready;
  logic                  rd_rsp_valid;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  logic                  wr_req_valid;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  wr_req_ready;
  logic                  wr_rsp_valid;

  modport master (
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
    output wr_req_valid, wr_req_addr, wr_req_data,
    input  wr_req_ready, wr_rsp_valid
  );

  modport slave (
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    output wr_req_ready, wr_rsp_valid
  );
endinterface

// File: rtl/hc_copy_core.sv
// Streaming copy core: reads N lines from buffer 0, XORs each with a constant,
// writes them in order to buffer 1 and raises finish once every write is acknowledged.
module hc_copy_core #(
  parameter int                    DATA_WIDTH = 512,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] XOR_MASK   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_lines,
  output logic                  finish,
  output logic                  busy,
  output logic [1:0]            dbg_state_o,
  hc_copy_core_if.master        bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = ADDR_WIDTH;
  localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          finish_q, finish_d;
  logic [AW-1:0] len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, ack_cnt_q, ack_cnt_d;
  logic [CW-1:0] inflight_q, inflight_d, count_q, count_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic active, push, ack_in, rd_fire, wr_fire, credit_ok;

  assign active  = (state_q == S_RUN) || (state_q == S_DRAIN);
  // Responses and acks outside a job are stale and dropped.
  assign push    = bus.rd_rsp_valid && active;
  assign ack_in  = bus.wr_rsp_valid && active;
  assign rd_fire = bus.rd_req_valid && bus.rd_req_ready;
  assign wr_fire = bus.wr_req_valid && bus.wr_req_ready;
  // Every issued read owns a FIFO slot, so a response can never find the FIFO full.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C;

  assign bus.rd_req_valid = (state_q == S_RUN) && (rd_cnt_q < len_q) && credit_ok;
  assign bus.rd_req_addr  = rd_cnt_q;
  assign bus.wr_req_valid = (count_q != '0);
  assign bus.wr_req_addr  = wr_cnt_q;
  assign bus.wr_req_data  = mem_q[rptr_q];
  assign finish      = finish_q;
  assign busy        = active;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d    = state_q;
    finish_d   = finish_q;
    len_d      = len_q;
    rd_cnt_d   = rd_fire ? rd_cnt_q + AW'(1) : rd_cnt_q;
    wr_cnt_d   = wr_fire ? wr_cnt_q + AW'(1) : wr_cnt_q;
    ack_cnt_d  = ack_in  ? ack_cnt_q + AW'(1) : ack_cnt_q;
    inflight_d = inflight_q;
    if (rd_fire && !push)      inflight_d = inflight_q + CW'(1);
    else if (!rd_fire && push) inflight_d = inflight_q - CW'(1);
    count_d = count_q;
    if (push && !wr_fire)      count_d = count_q + CW'(1);
    else if (!push && wr_fire) count_d = count_q - CW'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) finish_d = 1'b1;
        if (start) begin
          len_d      = num_lines;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          ack_cnt_d  = '0;
          inflight_d = '0;
          finish_d   = 1'b0;
          state_d    = (num_lines == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rd_cnt_q == len_q) begin
          if (ack_cnt_d == len_q) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Looking at the next ack count lets finish rise the cycle after the last ack.
        if (ack_cnt_d == len_q) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      finish_q   <= 1'b0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      ack_cnt_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      finish_q   <= finish_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push)    wptr_q <= wptr_q + PW'(1);
      if (wr_fire) rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.rd_rsp_data ^ XOR_MASK;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && (count_q == FULL_C)));
endmodule

// File: tb/tb_hc_copy_core.sv
// Bench for hc_copy_core: a randomized requestor model drives one core and checks
// every write against an in-order expected queue built from the source buffer.
module tb_hc_copy_core;
  localparam int DW = 64, AW = 16, DEPTH = 16, MAXL = 256;
  localparam logic [DW-1:0] MASK_X = '1;

  logic clk = 1'b0;
  logic reset, start, start_x, finish, busy, finish_x, busy_x;
  logic [AW-1:0] num_lines, num_lines_x;
  logic [1:0] dbg_state, dbg_state_x;

  hc_copy_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  hc_copy_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_x ();

  hc_copy_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .XOR_MASK('0)) dut (
    .clk(clk), .reset(reset), .start(start), .num_lines(num_lines), .finish(finish),
    .busy(busy), .dbg_state_o(dbg_state), .bus(bus));
  hc_copy_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .XOR_MASK(MASK_X)) dut_x (
    .clk(clk), .reset(reset), .start(start_x), .num_lines(num_lines_x), .finish(finish_x),
    .busy(busy_x), .dbg_state_o(dbg_state_x), .bus(bus_x));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference model: source buffer, expected write stream, requestor queues.
  logic [DW-1:0]    src [MAXL];
  logic [AW+DW-1:0] exp_q[$];
  int rsp_due[$]; logic [DW-1:0] rsp_dat[$]; int ack_due[$];
  int cyc = 0, start_cyc = -10, first_fin_cyc = -1, last_ack_cyc = -1;
  int exp_rd_addr, rd_acc, wr_acc, ack_cnt, max_out;
  int rd_lat = 1, wr_lat = 1, rd_pct = 100, wr_pct = 100, wr_block_until = 0;
  bit model_en = 0, busy_seen, fin_s1;
  bit prev_rd_stall, prev_wr_stall;
  logic [AW-1:0] prev_rd_addr, prev_wr_addr;
  logic [DW-1:0] prev_wr_data;
  bit x_rd_pend, x_wr_pend;
  int x_wr_cnt = 0;

  // Requestor driver: inputs change 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!model_en) begin
      bus.rd_rsp_valid = 1'b0; bus.wr_rsp_valid = 1'b0;
      bus.rd_req_ready = 1'b0; bus.wr_req_ready = 1'b0;
    end else begin
      if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_data  = rsp_dat.pop_front();
        void'(rsp_due.pop_front());
      end else begin
        bus.rd_rsp_valid = 1'b0;
        bus.rd_rsp_data  = {$urandom, $urandom};
      end
      if (ack_due.size() > 0 && ack_due[0] <= cyc) begin
        bus.wr_rsp_valid = 1'b1;
        void'(ack_due.pop_front());
      end else begin
        bus.wr_rsp_valid = 1'b0;
      end
      bus.rd_req_ready = ($urandom_range(99) < rd_pct);
      bus.wr_req_ready = (cyc >= wr_block_until) && ($urandom_range(99) < wr_pct);
    end
    bus_x.rd_req_ready = 1'b1;
    bus_x.wr_req_ready = 1'b1;
    bus_x.rd_rsp_valid = x_rd_pend;
    bus_x.rd_rsp_data  = '0;
    bus_x.wr_rsp_valid = x_wr_pend;
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (model_en && !reset) begin
      if (prev_rd_stall)
        check("rd_hold", {bus.rd_req_valid, bus.rd_req_addr}, {1'b1, prev_rd_addr});
      if (prev_wr_stall)
        check("wr_hold", {bus.wr_req_valid, bus.wr_req_addr, bus.wr_req_data},
              {1'b1, prev_wr_addr, prev_wr_data});
      if (bus.rd_req_valid && bus.rd_req_ready) begin
        check("rd_addr", bus.rd_req_addr, exp_rd_addr);
        rsp_due.push_back(cyc + rd_lat);
        rsp_dat.push_back(src[bus.rd_req_addr % MAXL]);
        exp_rd_addr++; rd_acc++;
      end
      if (bus.wr_req_valid && bus.wr_req_ready) begin
        if (exp_q.size() == 0) check("wr_extra", 1, 0);
        else check("wr_line", {bus.wr_req_addr, bus.wr_req_data}, exp_q.pop_front());
        ack_due.push_back(cyc + wr_lat);
        wr_acc++;
      end
      if (bus.rd_req_valid && bus.rd_req_ready) check("credit", (rd_acc - wr_acc) <= DEPTH, 1);
      if (rd_acc - wr_acc > max_out) max_out = rd_acc - wr_acc;
      if (bus.wr_rsp_valid) begin ack_cnt++; last_ack_cyc = cyc; end
      if (busy) busy_seen = 1;
      if (cyc == start_cyc + 1) fin_s1 = finish;
      if (finish && first_fin_cyc < 0 && cyc > start_cyc + 1) first_fin_cyc = cyc;
      prev_rd_stall = bus.rd_req_valid && !bus.rd_req_ready;
      prev_wr_stall = bus.wr_req_valid && !bus.wr_req_ready;
      prev_rd_addr  = bus.rd_req_addr;
      prev_wr_addr  = bus.wr_req_addr;
      prev_wr_data  = bus.wr_req_data;
    end else begin
      prev_rd_stall = 0; prev_wr_stall = 0;
    end
    if (!reset) begin
      if (bus_x.wr_req_valid && bus_x.wr_req_ready) begin
        check("xor_line", {bus_x.wr_req_addr, bus_x.wr_req_data}, {AW'(x_wr_cnt), MASK_X});
        x_wr_cnt++;
      end
      x_rd_pend = bus_x.rd_req_valid && bus_x.rd_req_ready;
      x_wr_pend = bus_x.wr_req_valid && bus_x.wr_req_ready;
    end else begin
      x_rd_pend = 0; x_wr_pend = 0;
    end
  end

  task automatic load_job(input int n, input bit idx_data);
    exp_q.delete();
    for (int i = 0; i < MAXL; i++) src[i] = idx_data ? DW'(i) : {$urandom, $urandom};
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), src[i]});
    exp_rd_addr = 0; rd_acc = 0; wr_acc = 0; ack_cnt = 0; max_out = 0;
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #2;
    start = 1'b1; num_lines = AW'(n); start_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0; first_fin_cyc = -1; busy_seen = 0;
  endtask

  task automatic run_job(input int n, input int rl, input int wl, input int rp, input int wp,
                         input int block, input bit idx_data);
    load_job(n, idx_data);
    rd_lat = rl; wr_lat = wl; rd_pct = rp; wr_pct = wp;
    pulse_start(n);
    wr_block_until = cyc + block;
    for (int k = 0; k < 5000 && first_fin_cyc < 0; k++) @(negedge clk);
    check("finish_seen", first_fin_cyc >= 0, 1);
    check("finish_drop", fin_s1, 0);
    check("rd_count", rd_acc, n);
    check("wr_count", wr_acc, n);
    check("ack_count", ack_cnt, n);
    check("exp_empty", exp_q.size(), 0);
    check("finish_lat", first_fin_cyc, (n == 0) ? start_cyc + 2 : last_ack_cyc + 1);
    check("busy_seen", busy_seen, n > 0);
    check("busy_done", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_valid"}, bus.rd_req_valid, 0);
    check({tag, "_wr_valid"}, bus.wr_req_valid, 0);
    check({tag, "_addrs"}, {bus.rd_req_addr, bus.wr_req_addr}, 0);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_x = 1'b0; num_lines = '0; num_lines_x = '0;
    bus.rd_req_ready = 0; bus.wr_req_ready = 0; bus.rd_rsp_valid = 0; bus.wr_rsp_valid = 0;
    bus.rd_rsp_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2;
    reset = 1'b0; model_en = 1;

    run_job(4, 1, 1, 100, 100, 0, 1);
    run_job(0, 1, 1, 100, 100, 0, 1);
    run_job(64, 20, 3, 100, 100, 100, 0);
    check("credit_peak", max_out, DEPTH);
    run_job(200, $urandom_range(1, 6), $urandom_range(1, 4), 60, 60, 0, 0);

    // Reset part-way through a 32-line job.
    load_job(32, 0);
    rd_lat = 2; wr_lat = 2; rd_pct = 100; wr_pct = 50;
    pulse_start(32);
    for (int k = 0; k < 2000 && wr_acc < 10; k++) @(negedge clk);
    check("mid_wr_reached", wr_acc >= 10, 1);
    #1 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    model_en = 0;
    rsp_due.delete(); rsp_dat.delete(); ack_due.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0; model_en = 1;
    run_job(5, 1, 1, 100, 100, 0, 1);

    // All-ones mask: zero data reads must be written as all ones.
    @(posedge clk); #2;
    start_x = 1'b1; num_lines_x = AW'(2);
    @(posedge clk); #2;
    start_x = 1'b0;
    for (int k = 0; k < 200 && !finish_x; k++) @(negedge clk);
    check("xor_finish", finish_x, 1);
    check("xor_writes", x_wr_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
